// File: rtl/serial_transfer_pkg.sv
// serial_transfer_pkg: shared types and sizing helpers for the serial transfer unit.
// Optional feature macro: SERIAL_PARITY_EN (appends an even-parity bit after the LSB).
package serial_transfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

`ifdef SERIAL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Number of serial bits sent per word.
  function automatic int tx_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Counter must hold the value LEN without wrapping.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/serial_transfer_unit_tx_shift_reg.sv
// tx_shift_reg: parallel-load, MSB-first shift register for the serial transfer unit.
// Optional feature macro: SERIAL_PARITY_EN (stores even parity of the word as the last bit).
module tx_shift_reg
  import serial_transfer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = tx_len(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [LEN-1:0] r_sreg;
  logic [LEN-1:0] w_load_val;

`ifdef SERIAL_PARITY_EN
  // Even parity: the extra bit makes the total count of ones even.
  assign w_load_val = {i_data, ^i_data};
`else
  assign w_load_val = i_data;
`endif

  // Load wins over shift; the FSM never asserts both in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= w_load_val;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[LEN-2:0], 1'b0};
    end
  end

  assign o_msb = r_sreg[LEN-1];

endmodule

// File: rtl/serial_transfer_unit.sv
// serial_transfer_unit: captures a result word and shifts it out MSB first.
// Optional feature macro: SERIAL_PARITY_EN (adds a trailing even-parity bit).
//
// state  | meaning
// IDLE   | waiting for SampleData; TransferData ignored
// LOADED | word captured; re-capture allowed, TransferData starts the shift
// SHIFT  | presenting bits while TransferData is high, pausing while low
// DONE   | TransferDone pulse cycle; returns to IDLE unconditionally
module serial_transfer_unit
  import serial_transfer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SampleData,
  input  logic             TransferData,
  input  logic [WIDTH-1:0] InData,
  output logic             DataOut,
  output logic             OutValid,
  output logic             TransferDone,
  output logic             TxBusy
);

  localparam int             LEN  = tx_len(WIDTH);
  localparam int             CW   = cnt_width(LEN);
  localparam logic [CW-1:0]  LAST = CW'(LEN);

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_data_out;
  logic          r_out_valid;
  logic          r_done;

  logic w_load;
  logic w_start;
  logic w_last_sent;
  logic w_shift;
  logic w_msb;

  // Capture is only honoured before the transfer starts; capture beats start in LOADED.
  assign w_load      = SampleData && ((r_state == IDLE) || (r_state == LOADED));
  assign w_start     = (r_state == LOADED) && TransferData && !SampleData;
  assign w_last_sent = (r_cnt == LAST);
  assign w_shift     = w_start || ((r_state == SHIFT) && TransferData && !w_last_sent);

  tx_shift_reg #(
    .WIDTH (WIDTH),
    .LEN   (LEN)
  ) u_shift (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (InData),
    .o_msb   (w_msb)
  );

  // FSM, bit counter and registered serial outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_data_out  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (SampleData) r_state <= LOADED;
        end
        LOADED: begin
          if (w_start) begin
            r_state     <= SHIFT;
            r_data_out  <= w_msb;
            r_out_valid <= 1'b1;
            r_cnt       <= CW'(1);
          end
        end
        SHIFT: begin
          if (w_last_sent) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (TransferData) begin
            r_data_out  <= w_msb;
            r_out_valid <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DataOut      = r_data_out;
  assign OutValid     = r_out_valid;
  assign TransferDone = r_done;
  assign TxBusy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_transfer_unit.sv
// tb_serial_transfer_unit: directed self-checking bench for serial_transfer_unit (WIDTH=8).
// Expected bit patterns follow SERIAL_PARITY_EN when the bench is built with it.
module tb_serial_transfer_unit;

`ifdef SERIAL_PARITY_EN
  localparam int LEN = 9;
  localparam logic [LEN-1:0] EXP_A5 = 9'b1010_0101_0;
  localparam logic [LEN-1:0] EXP_FF = 9'b1111_1111_0;
  localparam logic [LEN-1:0] EXP_07 = 9'b0000_0111_1;
`else
  localparam int LEN = 8;
  localparam logic [LEN-1:0] EXP_A5 = 8'hA5;
  localparam logic [LEN-1:0] EXP_FF = 8'hFF;
`endif

  logic       Clk;
  logic       Reset;
  logic       SampleData;
  logic       TransferData;
  logic [7:0] InData;
  logic       DataOut;
  logic       OutValid;
  logic       TransferDone;
  logic       TxBusy;

  int vectors;
  int miscompares;

  serial_transfer_unit #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SampleData   (SampleData),
    .TransferData (TransferData),
    .InData       (InData),
    .DataOut      (DataOut),
    .OutValid     (OutValid),
    .TransferDone (TransferDone),
    .TxBusy       (TxBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; SampleData = 1'b0; TransferData = 1'b0; InData = 8'h00;
    tick();
    vectors++;
    if ({DataOut, OutValid, TransferDone, TxBusy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000", {DataOut, OutValid, TransferDone, TxBusy});
    end
    Reset = 1'b1;
    tick();
    vectors++;
    if (TxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_busy: got %b want 0", TxBusy);
    end
  endtask

  task automatic test_basic();
    SampleData = 1'b1; InData = 8'hA5;
    tick();
    SampleData = 1'b0;
    vectors++;
    if (TxBusy !== 1'b1 || OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_loaded: busy=%b valid=%b want busy=1 valid=0", TxBusy, OutValid);
    end
    TransferData = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b1 || DataOut !== EXP_A5[LEN-1-i]) begin
        miscompares++;
        $display("FAIL basic_bit%0d: valid=%b data=%b want valid=1 data=%b", i, OutValid, DataOut, EXP_A5[LEN-1-i]);
      end
    end
    tick();
    vectors++;
    if (OutValid !== 1'b0 || TransferDone !== 1'b1 || TxBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: valid=%b done=%b busy=%b want 0 1 1", OutValid, TransferDone, TxBusy);
    end
    tick();
    TransferData = 1'b0;
    vectors++;
    if (TransferDone !== 1'b0 || TxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: done=%b busy=%b want 0 0", TransferDone, TxBusy);
    end
  endtask

  task automatic test_pause();
    SampleData = 1'b1; InData = 8'hA5;
    tick();
    SampleData = 1'b0; TransferData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b1 || DataOut !== EXP_A5[LEN-1-i]) begin
        miscompares++;
        $display("FAIL pause_pre_bit%0d: valid=%b data=%b want valid=1 data=%b", i, OutValid, DataOut, EXP_A5[LEN-1-i]);
      end
    end
    TransferData = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b0 || DataOut !== 1'b1 || TxBusy !== 1'b1 || TransferDone !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_hold%0d: valid=%b data=%b busy=%b done=%b want 0 1 1 0", i, OutValid, DataOut, TxBusy, TransferDone);
      end
    end
    TransferData = 1'b1;
    for (int i = 3; i < LEN; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b1 || DataOut !== EXP_A5[LEN-1-i]) begin
        miscompares++;
        $display("FAIL pause_post_bit%0d: valid=%b data=%b want valid=1 data=%b", i, OutValid, DataOut, EXP_A5[LEN-1-i]);
      end
    end
    tick();
    vectors++;
    if (TransferDone !== 1'b1 || OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_done: done=%b valid=%b want 1 0", TransferDone, OutValid);
    end
    tick();
    TransferData = 1'b0;
    vectors++;
    if (TxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_idle: busy=%b want 0", TxBusy);
    end
  endtask

  task automatic test_resample();
    SampleData = 1'b1; InData = 8'h3C;
    tick();
    InData = 8'hFF; TransferData = 1'b1;
    tick();
    vectors++;
    if (OutValid !== 1'b0 || TxBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL resample_priority: valid=%b busy=%b want 0 1", OutValid, TxBusy);
    end
    SampleData = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      tick();
      SampleData = 1'b1; InData = 8'h00;
      vectors++;
      if (OutValid !== 1'b1 || DataOut !== EXP_FF[LEN-1-i]) begin
        miscompares++;
        $display("FAIL resample_bit%0d: valid=%b data=%b want valid=1 data=%b", i, OutValid, DataOut, EXP_FF[LEN-1-i]);
      end
    end
    SampleData = 1'b0;
    tick();
    vectors++;
    if (TransferDone !== 1'b1) begin
      miscompares++;
      $display("FAIL resample_done: done=%b want 1", TransferDone);
    end
    tick();
    TransferData = 1'b0;
  endtask

  task automatic test_idle_transfer();
    TransferData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b0 || TransferDone !== 1'b0 || TxBusy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_td%0d: valid=%b done=%b busy=%b want 0 0 0", i, OutValid, TransferDone, TxBusy);
      end
    end
    TransferData = 1'b0;
  endtask

  task automatic test_reset_mid();
    SampleData = 1'b1; InData = 8'hA5;
    tick();
    SampleData = 1'b0; TransferData = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (OutValid !== 1'b1 || DataOut !== EXP_A5[LEN-4]) begin
      miscompares++;
      $display("FAIL rstmid_bit3: valid=%b data=%b want 1 %b", OutValid, DataOut, EXP_A5[LEN-4]);
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if ({DataOut, OutValid, TransferDone, TxBusy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b want 0000", {DataOut, OutValid, TransferDone, TxBusy});
    end
    tick();
    #2;
    Reset = 1'b1;
    for (int i = 0; i < LEN + 2; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b0 || TransferDone !== 1'b0 || TxBusy !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: valid=%b done=%b busy=%b want 0 0 0", i, OutValid, TransferDone, TxBusy);
      end
    end
    TransferData = 1'b0;
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    SampleData = 1'b1; InData = 8'h07;
    tick();
    SampleData = 1'b0; TransferData = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      tick();
      vectors++;
      if (OutValid !== 1'b1 || DataOut !== EXP_07[LEN-1-i]) begin
        miscompares++;
        $display("FAIL parity07_bit%0d: valid=%b data=%b want valid=1 data=%b", i, OutValid, DataOut, EXP_07[LEN-1-i]);
      end
    end
    tick();
    vectors++;
    if (TransferDone !== 1'b1 || OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL parity07_done: done=%b valid=%b want 1 0", TransferDone, OutValid);
    end
    tick();
    TransferData = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_pause();
    test_resample();
    test_idle_transfer();
    test_reset_mid();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_transfer_unit.md
# serial_transfer_unit

Downstream data stage of the binary calculator. Captures a result word when the controller raises SampleData, then shifts it out serially, MSB first, while the controller holds TransferData. It pulses TransferDone after the last bit, which closes the controller's read/write flow. Sits between the memory/ALU result bus and the serial output pin.

## Interface

Parameters:
- WIDTH, default 8, data word width in bits (≥ 2).

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, asynchronous, active-low; asserting it clears all state immediately.
- SampleData, input, 1, capture InData into the shift register.
- TransferData, input, 1, shift enable; held high by the controller for the whole transfer.
- InData, input, WIDTH, result word to transmit.
- DataOut, output, 1, serial bit; registered.
- OutValid, output, 1, DataOut carries a valid bit this cycle; registered.
- TransferDone, output, 1, one-cycle pulse after the final bit; registered.
- TxBusy, output, 1, high in every state other than IDLE.

## Operation

- States (tx_state_t): IDLE, LOADED, SHIFT, DONE.
- IDLE:
  - SampleData=1 → capture InData, go to LOADED.
  - TransferData alone is ignored.
- LOADED:
  - SampleData=1 → re-capture; the last sample wins.
  - TransferData=1 → go to SHIFT, present the MSB, OutValid=1, bit counter=1.
  - If both are high in the same cycle, the re-capture takes priority and the transfer starts on the next edge where TransferData is still high.
- SHIFT:
  - Each edge with TransferData=1 presents the next bit and increments the counter.
  - TransferData=0 pauses the transfer: OutValid=0, DataOut holds its value, the counter holds.
  - SampleData is ignored.
  - On the edge after the last bit has been presented: OutValid=0, TransferDone=1, go to DONE.
- DONE: TransferDone drops to 0 and the block returns to IDLE unconditionally on the next edge.
- Bit counter width is $clog2(LEN+1), where LEN = WIDTH (or WIDTH+1 with parity). The counter never wraps.
- Reset values: state=IDLE, shift register=0, counter=0, DataOut=0, OutValid=0, TransferDone=0, TxBusy=0.
- Reset asserted mid-transfer aborts the transfer silently; no TransferDone is issued.

## Timing

- Capture latency: 1 edge (SampleData sampled at edge k puts the block in LOADED after edge k).
- First bit: appears on DataOut in the cycle after the edge that samples TransferData=1 in LOADED.
- Uninterrupted transfer: LEN consecutive OutValid cycles, then TransferDone high for exactly 1 cycle.
- Total from transfer start to the TransferDone cycle: LEN+1 edges.
- TxBusy is combinational from the state register.

## Configuration

- Macro SERIAL_PARITY_EN.
- Defined:
  - An even-parity bit over InData is computed and stored at capture time.
  - It is sent as bit LEN after the LSB, so LEN = WIDTH+1.
- Undefined: no parity logic is compiled in, and LEN = WIDTH.

## Structure

- Package serial_transfer_pkg holds:
  - the tx_state_t enum;
  - the constant LEN expression;
  - the helper function for counter width.
- Sub-module tx_shift_reg holds the load/shift register: parallel load, MSB-first shift with enable, and the optional parity bit.
- The top level holds the FSM and the counter.

## Test plan

- Basic transfer: WIDTH=8, sample 8'hA5, hold TransferData.
  - DataOut sequence 1,0,1,0,0,1,0,1 with OutValid high for 8 cycles.
  - TransferDone high for 1 cycle, then TxBusy=0.
- Pause: drop TransferData for 2 cycles after 3 bits of 8'hA5.
  - OutValid=0 and DataOut=1 held during the pause.
  - The remaining bits 0,0,1,0,1 follow, then TransferDone.
- Re-sample in LOADED: sample 8'h3C, then 8'hFF, then transfer.
  - Eight 1s are sent.
  - SampleData=8'h00 during SHIFT does not change the output.
- Idle TransferData: pulse TransferData in IDLE.
  - No OutValid, no TransferDone, TxBusy stays 0.
- Reset mid-transfer: assert Reset after 4 bits.
  - All outputs go to 0 immediately.
  - No TransferDone; the block is in IDLE after Reset is released.
- SERIAL_PARITY_EN defined:
  - 8'hA5 → 9 bits, last bit 0.
  - 8'h07 → last bit 1.
  - TransferDone follows the 9th bit.
